// File: rtl/diag_matmul_stream_if.sv
// diag_matmul_stream_if: start/A/B/C stream handshakes and job status for diag_matmul_stream
// Ports: master drives start, a_valid/a_data, b_valid/b_data, c_ready; slave drives a_ready, b_ready,
//        c_valid/c_data/c_last, busy, done, ovf
interface diag_matmul_stream_if #(parameter int DATA_W = 32);
  logic start, a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, c_last, busy, done, ovf;
  logic [DATA_W-1:0] a_data, b_data, c_data;
  modport master (
    output start, a_valid, a_data, b_valid, b_data, c_ready,
    input  a_ready, b_ready, c_valid, c_data, c_last, busy, done, ovf
  );
  modport slave (
    input  start, a_valid, a_data, b_valid, b_data, c_ready,
    output a_ready, b_ready, c_valid, c_data, c_last, busy, done, ovf
  );
endinterface

// File: rtl/diag_matmul_stream.sv
// diag_matmul_stream: streams C[i][j] = A[i] * B[i][j] with fixed-point shift, saturate/wrap and ready/valid on every stream
// Ports: clk, rst_n (async active-low); bus (slave) carries start, A/B input streams, C output stream, busy/done/ovf
module diag_matmul_stream #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int FRAC   = 0,
  parameter int SAT    = 1
) (
  input logic clk,
  input logic rst_n,
  diag_matmul_stream_if.slave bus
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  typedef enum logic [1:0] {IDLE, LOAD_A, STREAM, DRAIN} state_t;
  state_t state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [DATA_W-1:0] a_buf_q [ROWS];
  logic [DATA_W-1:0] c_data_q, res_d;
  logic c_valid_q, c_last_q, done_q, ovf_q;
  logic signed [2*DATA_W-1:0] prod_d, shift_d;
  logic [DATA_W:0] top_d;
  logic ovf_d, row_end, col_end, a_hs, b_hs, c_hs;
  // Row counter doubles as the A buffer write index while loading
  always_comb begin
    prod_d  = $signed(a_buf_q[row_q]) * $signed(bus.b_data);
    shift_d = prod_d >>> FRAC;
    top_d   = shift_d[2*DATA_W-1:DATA_W-1];
    ovf_d   = !(&top_d || ~|top_d);
    res_d   = (ovf_d && SAT != 0)
            ? (shift_d[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
            : shift_d[DATA_W-1:0];
  end
  assign row_end     = row_q == RW'(ROWS - 1);
  assign col_end     = col_q == CW'(COLS - 1);
  assign bus.a_ready = state_q == LOAD_A;
  // One-entry output register: accept B whenever the slot is empty or draining this cycle
  assign bus.b_ready = state_q == STREAM && (!c_valid_q || bus.c_ready);
  assign a_hs        = bus.a_ready && bus.a_valid;
  assign b_hs        = bus.b_ready && bus.b_valid;
  assign c_hs        = c_valid_q && bus.c_ready;
  assign bus.c_valid = c_valid_q;
  assign bus.c_data  = c_data_q;
  assign bus.c_last  = c_last_q;
  assign bus.busy    = state_q != IDLE;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  always_ff @(posedge clk)
    if (a_hs) a_buf_q[row_q] <= bus.a_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
      c_last_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= LOAD_A;
          row_q   <= '0;
          col_q   <= '0;
          ovf_q   <= 1'b0;
        end
        LOAD_A: if (a_hs) begin
          row_q <= row_end ? '0 : row_q + 1'b1;
          if (row_end) state_q <= STREAM;
        end
        STREAM: begin
          if (c_hs) c_valid_q <= 1'b0;
          if (b_hs) begin
            c_data_q  <= res_d;
            c_valid_q <= 1'b1;
            c_last_q  <= row_end && col_end;
            ovf_q     <= ovf_q | ovf_d;
            col_q     <= col_end ? '0 : col_q + 1'b1;
            if (col_end) row_q <= row_end ? '0 : row_q + 1'b1;
            if (row_end && col_end) state_q <= DRAIN;
          end
        end
        default: if (c_hs && c_last_q) begin
          c_valid_q <= 1'b0;
          c_last_q  <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
endmodule
